// File: rtl/mips_pkg.sv
// Shared decode definitions for the MIPS-subset pipeline: opcodes, functs,
// ALU codes, control bundle and the small decode helpers.
package mips_pkg;

  localparam int NUM_REGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    illegal;
  } ctrl_t;

  // ID/EX pipeline bundle; an all-zero value is a bubble.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    ctrl_t       ctrl;
  } idex_t;

  localparam ctrl_t CTRL_NONE = '{ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Control fields for one instruction word; the all-zero word is a NOP.
  function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
    ctrl_t c;
    c = CTRL_NONE;
    if (instr == 32'h0000_0000) begin
      c = CTRL_NONE;
    end else begin
      case (instr[31:26])
        OP_RTYPE: begin
          c.reg_write = 1'b1;
          case (instr[5:0])
            FN_ADD:  c.alu_op = ALU_ADD;
            FN_SUB:  c.alu_op = ALU_SUB;
            FN_AND:  c.alu_op = ALU_AND;
            FN_OR:   c.alu_op = ALU_OR;
            FN_SLT:  c.alu_op = ALU_SLT;
            default: begin
              c.reg_write = 1'b0;
              c.illegal   = 1'b1;
            end
          endcase
        end
        OP_ADDI: begin
          c.alu_src   = 1'b1;
          c.reg_write = 1'b1;
        end
        OP_LW: begin
          c.alu_src    = 1'b1;
          c.mem_read   = 1'b1;
          c.mem_to_reg = 1'b1;
          c.reg_write  = 1'b1;
        end
        OP_SW: begin
          c.alu_src   = 1'b1;
          c.mem_write = 1'b1;
        end
        OP_BEQ: begin
          c.alu_op = ALU_SUB;
        end
        default: c.illegal = 1'b1;
      endcase
    end
    return c;
  endfunction

  // Destination register: rd for R-type, rt for ADDI/LW, otherwise none.
  function automatic logic [4:0] dest_sel(input logic [31:0] instr, input logic illegal);
    logic [4:0] d;
    d = 5'd0;
    if (illegal) begin
      d = 5'd0;
    end else begin
      case (instr[31:26])
        OP_RTYPE:      d = instr[15:11];
        OP_ADDI, OP_LW: d = instr[20:16];
        default:       d = 5'd0;
      endcase
    end
    return d;
  endfunction

  // True where rt is read as a source operand (and so can cause a hazard).
  function automatic logic uses_rt(input logic [5:0] opcode);
    logic u;
    case (opcode)
      OP_RTYPE, OP_SW, OP_BEQ: u = 1'b1;
      default:                 u = 1'b0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports with write-first bypass,
// one write port, $0 hardwired to zero, synchronous clear on reset.
module reg_file
  import mips_pkg::*;
#(
  parameter int N = NUM_REGS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra_addr,
  input  logic [4:0]  rb_addr,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [N];
  logic [31:0] regs_d [N];

  // Next register contents: apply the write-back, keep $0 at zero.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) begin
      regs_d[waddr] = wdata;
    end else begin
      regs_d[waddr] = regs_q[waddr];
    end
    regs_d[0] = 32'h0000_0000;
  end

  // Register array state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports; a same-cycle write to the addressed register is forwarded.
  always_comb begin
    ra_data = regs_q[ra_addr];
    rb_data = regs_q[rb_addr];
    if (ra_addr == 5'd0) begin
      ra_data = 32'h0000_0000;
    end else if (we && (waddr == ra_addr)) begin
      ra_data = wdata;
    end else begin
      ra_data = regs_q[ra_addr];
    end
    if (rb_addr == 5'd0) begin
      rb_data = 32'h0000_0000;
    end else if (we && (waddr == rb_addr)) begin
      rb_data = wdata;
    end else begin
      rb_data = regs_q[rb_addr];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, decode, register read with bypass,
// load-use stall generation and the registered ID/EX bundle.
module id_stage
  import mips_pkg::*;
#(
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction_in,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_dest,
  output logic [2:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_illegal
);

  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  idex_t       idex_q, idex_d;

  logic [4:0]  rs_addr_s, rt_addr_s;
  logic [31:0] rs_data_s, rt_data_s;
  ctrl_t       ctrl_s;
  idex_t       decoded_s;
  logic        stall_s;

  assign rs_addr_s = if_instr_q[25:21];
  assign rt_addr_s = if_instr_q[20:16];

  reg_file #(.N(NUM_REGS)) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (rs_addr_s),
    .rb_addr (rt_addr_s),
    .ra_data (rs_data_s),
    .rb_data (rt_data_s),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  // Decode the IF/ID instruction and detect a load-use hazard against ID/EX.
  always_comb begin
    ctrl_s            = decode_ctrl(if_instr_q);
    decoded_s.pc      = if_pc_q;
    decoded_s.rs_data = rs_data_s;
    decoded_s.rt_data = rt_data_s;
    decoded_s.imm     = {{16{if_instr_q[15]}}, if_instr_q[15:0]};
    decoded_s.rs      = rs_addr_s;
    decoded_s.rt      = rt_addr_s;
    decoded_s.dest    = dest_sel(if_instr_q, ctrl_s.illegal);
    decoded_s.ctrl    = ctrl_s;
    stall_s = ~flush & idex_q.ctrl.mem_read & (idex_q.dest != 5'd0) &
              ((idex_q.dest == rs_addr_s) |
               (uses_rt(if_instr_q[31:26]) & (idex_q.dest == rt_addr_s)));
  end

  // Pipeline register next state: flush beats stall, stall holds IF/ID.
  always_comb begin
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    idex_d     = '0;
    if (flush) begin
      if_pc_d    = RESET_PC;
      if_instr_d = 32'h0000_0000;
      idex_d     = '0;
    end else if (stall_s) begin
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      idex_d     = '0;
    end else begin
      if_pc_d    = pc_in;
      if_instr_d = instruction_in;
      idex_d     = decoded_s;
    end
  end

  // IF/ID and ID/EX registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_pc_q    <= RESET_PC;
      if_instr_q <= 32'h0000_0000;
      idex_q     <= '0;
    end else begin
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      idex_q     <= idex_d;
    end
  end

  assign stall         = stall_s;
  assign ex_pc         = idex_q.pc;
  assign ex_rs_data    = idex_q.rs_data;
  assign ex_rt_data    = idex_q.rt_data;
  assign ex_imm        = idex_q.imm;
  assign ex_rs         = idex_q.rs;
  assign ex_rt         = idex_q.rt;
  assign ex_dest       = idex_q.dest;
  assign ex_alu_op     = idex_q.ctrl.alu_op;
  assign ex_alu_src    = idex_q.ctrl.alu_src;
  assign ex_reg_write  = idex_q.ctrl.reg_write;
  assign ex_mem_read   = idex_q.ctrl.mem_read;
  assign ex_mem_write  = idex_q.ctrl.mem_write;
  assign ex_mem_to_reg = idex_q.ctrl.mem_to_reg;
  assign ex_illegal    = idex_q.ctrl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: table of single-instruction decode
// vectors plus hand sequences for stall, bypass, flush and reset.
module tb_id_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;

  id_stage dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instruction_in(instruction_in),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, dest;
    logic [2:0]  alu_op;
    logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg, illegal;
  } ex_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    ex_t         exp;
  } vec_t;

  ex_t  act;
  vec_t vecs[12];
  int   n_cmp = 0;
  int   n_bad = 0;

  assign act = {ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest, ex_alu_op,
                ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {alu_src, reg_write, mem_read, mem_write, mem_to_reg, illegal}
  function automatic ex_t mk(input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd,
                             input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] dest, input logic [2:0] alu, input logic [5:0] flags);
    return {pc, rsd, rtd, imm, rs, rt, dest, alu, flags};
  endfunction

  task automatic chk_ex(input string nm, input ex_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clk);
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
  endtask

  // Present one instruction, follow with a NOP, sample once it reaches ID/EX.
  task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
    @(negedge clk);
    pc_in = pc; instruction_in = instr;
    @(negedge clk);
    pc_in = 32'h0; instruction_in = 32'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{"add",   32'h100, 32'h00221820, mk(32'h100, 32'd5, 32'd7,  32'h00001820, 5'd1, 5'd2, 5'd3, 3'd0, 6'b010000)};
    vecs[1]  = '{"sub",   32'h104, 32'h00222822, mk(32'h104, 32'd5, 32'd7,  32'h00002822, 5'd1, 5'd2, 5'd5, 3'd1, 6'b010000)};
    vecs[2]  = '{"and",   32'h108, 32'h00413024, mk(32'h108, 32'd7, 32'd5,  32'h00003024, 5'd2, 5'd1, 5'd6, 3'd2, 6'b010000)};
    vecs[3]  = '{"or",    32'h10C, 32'h00233825, mk(32'h10C, 32'd5, 32'd11, 32'h00003825, 5'd1, 5'd3, 5'd7, 3'd3, 6'b010000)};
    vecs[4]  = '{"slt",   32'h110, 32'h0022402A, mk(32'h110, 32'd5, 32'd7,  32'h0000402A, 5'd1, 5'd2, 5'd8, 3'd4, 6'b010000)};
    vecs[5]  = '{"addi",  32'h114, 32'h2004FFFF, mk(32'h114, 32'd0, 32'd0,  32'hFFFFFFFF, 5'd0, 5'd4, 5'd4, 3'd0, 6'b110000)};
    vecs[6]  = '{"lw",    32'h118, 32'h8C410004, mk(32'h118, 32'd7, 32'd5,  32'h00000004, 5'd2, 5'd1, 5'd1, 3'd0, 6'b111010)};
    vecs[7]  = '{"sw",    32'h11C, 32'hAC23FFF8, mk(32'h11C, 32'd5, 32'd11, 32'hFFFFFFF8, 5'd1, 5'd3, 5'd0, 3'd0, 6'b100100)};
    vecs[8]  = '{"beq",   32'h120, 32'h10220003, mk(32'h120, 32'd5, 32'd7,  32'h00000003, 5'd1, 5'd2, 5'd0, 3'd1, 6'b000000)};
    vecs[9]  = '{"ill_op", 32'h124, 32'hFC221820, mk(32'h124, 32'd5, 32'd7, 32'h00001820, 5'd1, 5'd2, 5'd0, 3'd0, 6'b000001)};
    vecs[10] = '{"ill_fn", 32'h128, 32'h00221821, mk(32'h128, 32'd5, 32'd7, 32'h00001821, 5'd1, 5'd2, 5'd0, 3'd0, 6'b000001)};
    vecs[11] = '{"nop",   32'h200, 32'h00000000, mk(32'h200, 32'd0, 32'd0,  32'h00000000, 5'd0, 5'd0, 5'd0, 3'd0, 6'b000000)};

    reset = 1'b1; flush = 1'b0; pc_in = 32'h0; instruction_in = 32'h0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_ex("reset_idle_ex", '0);
    chk_bit("reset_idle_stall", stall, 1'b0);

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    wb_write(5'd3, 32'd11);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].pc, vecs[i].instr);
      chk_ex(vecs[i].name, vecs[i].exp);
      chk_bit({vecs[i].name, "_stall"}, stall, 1'b0);
    end

    // Load-use: LW $1 then ADD $3,$1,$2; write $2=20 on the stall edge.
    @(negedge clk); pc_in = 32'h300; instruction_in = 32'h8C410004;
    @(negedge clk); pc_in = 32'h304; instruction_in = 32'h00221820;
    @(posedge clk); #1;
    chk_bit("lu_stall_hi", stall, 1'b1);
    chk_ex("lu_lw", mk(32'h300, 32'd7, 32'd5, 32'h4, 5'd2, 5'd1, 5'd1, 3'd0, 6'b111010));
    @(negedge clk); wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd20;
    @(posedge clk); #1;
    chk_ex("lu_bubble", '0);
    chk_bit("lu_stall_lo", stall, 1'b0);
    @(negedge clk); wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; pc_in = 32'h0; instruction_in = 32'h0;
    @(posedge clk); #1;
    chk_ex("lu_add", mk(32'h304, 32'd5, 32'd20, 32'h1820, 5'd1, 5'd2, 5'd3, 3'd0, 6'b010000));
    chk_bit("lu_after_stall", stall, 1'b0);

    // Bypass: SUB $5,$4,$3 decoded while $4 is written with 9.
    @(negedge clk); pc_in = 32'h400; instruction_in = 32'h00832822;
    @(negedge clk); pc_in = 32'h0; instruction_in = 32'h0; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'd9;
    @(posedge clk); #1;
    chk_ex("bypass_sub", mk(32'h400, 32'd9, 32'd11, 32'h2822, 5'd4, 5'd3, 5'd5, 3'd1, 6'b010000));

    // Write to $0 is neither forwarded nor stored.
    @(negedge clk); wb_en = 1'b0; pc_in = 32'h404; instruction_in = 32'h00005020;
    @(negedge clk); pc_in = 32'h0; instruction_in = 32'h0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk_ex("r0_bypass", mk(32'h404, 32'd0, 32'd0, 32'h5020, 5'd0, 5'd0, 5'd10, 3'd0, 6'b010000));
    @(negedge clk); wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    issue(32'h408, 32'h00045820);
    chk_ex("r0_store", mk(32'h408, 32'd0, 32'd9, 32'h5820, 5'd0, 5'd4, 5'd11, 3'd0, 6'b010000));

    // Flush during a stall.
    @(negedge clk); pc_in = 32'h500; instruction_in = 32'h8C410004;
    @(negedge clk); pc_in = 32'h504; instruction_in = 32'h00221820;
    @(posedge clk); #1;
    chk_bit("fl_stall_hi", stall, 1'b1);
    @(negedge clk); flush = 1'b1; #1;
    chk_bit("fl_stall_forced", stall, 1'b0);
    @(posedge clk); #1;
    chk_ex("fl_bubble", '0);
    @(negedge clk); flush = 1'b0; pc_in = 32'h0; instruction_in = 32'h0;
    @(posedge clk); #1;
    chk_ex("fl_ifid_nop", '0);
    chk_bit("fl_stall_lo", stall, 1'b0);

    // Reset mid-stall clears pipeline and register file.
    @(negedge clk); pc_in = 32'h600; instruction_in = 32'h8C410004;
    @(negedge clk); pc_in = 32'h604; instruction_in = 32'h00221820;
    @(posedge clk); #1;
    chk_bit("rs_stall_hi", stall, 1'b1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk_ex("rs_ex", '0);
    chk_bit("rs_stall_lo", stall, 1'b0);
    @(negedge clk); reset = 1'b0; pc_in = 32'h0; instruction_in = 32'h0;
    @(posedge clk); #1;
    chk_ex("rs_ifid_nop", '0);
    issue(32'h700, 32'h00221820);
    chk_ex("rs_rf_clear", mk(32'h700, 32'd0, 32'd0, 32'h1820, 5'd1, 5'd2, 5'd3, 3'd0, 6'b010000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage directly downstream of the instruction-fetch stage. It latches the fetched PC and instruction into an IF/ID register, decodes the instruction, and reads a 32x32 register file with write-back bypass. It detects load-use hazards and drives the fetch stage's stall input. Results go to a registered ID/EX bundle consumed by the execute stage.

Parameters:
NUM_REGS, 32, register-file depth; fixed at 32 for this ISA.
RESET_PC, 32'h0, value loaded into the IF/ID PC on reset and flush.

Ports:
clk  in  1  system clock, posedge
reset  in  1  synchronous, active-high
pc_in  in  32  PC from fetch stage
instruction_in  in  32  instruction from fetch stage
flush  in  1  discard IF/ID and ID/EX contents (branch taken)
wb_en  in  1  register-file write enable from write-back
wb_addr  in  5  write-back destination
wb_data  in  32  write-back data
stall  out  1  combinational; 1 = fetch must hold PC
ex_pc  out  32  PC of the decoded instruction
ex_rs_data  out  32  operand A
ex_rt_data  out  32  operand B / store data
ex_imm  out  32  sign-extended imm[15:0]
ex_rs  out  5  rs field
ex_rt  out  5  rt field
ex_dest  out  5  rd for R-type; rt for ADDI/LW; 0 otherwise
ex_alu_op  out  3  ALU operation code
ex_alu_src  out  1  1 = use ex_imm as operand B
ex_reg_write  out  1  write-back enable
ex_mem_read  out  1  load
ex_mem_write  out  1  store
ex_mem_to_reg  out  1  write-back takes memory data
ex_illegal  out  1  1 = instruction was not decodable

Behaviour:
- Clock and reset: all state updates on posedge clk. Reset is synchronous and active-high, and takes priority over all other inputs.
- Reset state:
  - IF/ID instruction = 0 (NOP); IF/ID PC = RESET_PC.
  - Every ID/EX output = 0.
  - All register-file entries = 0.
  - stall = 0.
- Latency: instruction presented on cycle N is captured at edge N. It is decoded during cycle N+1. Its ID/EX outputs are valid after edge N+1.
- Decode:
  - R-type (opcode 0): funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Sets reg_write=1, alu_src=0, dest=rd.
  - ADDI (001000): ADD, alu_src=1, reg_write=1, dest=rt.
  - LW (100011): ADD, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, dest=rt.
  - SW (101011): ADD, alu_src=1, mem_write=1, reg_write=0.
  - BEQ (000100): SUB, alu_src=0, no write. Branch resolution is handled downstream.
  - All-zero word: NOP. All control fields 0; ex_illegal=0.
  - Any other opcode/funct: all control fields 0 and ex_illegal=1.
- Immediate: ex_imm = {{16{imm[15]}}, imm[15:0]}.
- Register file:
  - $0 reads 0 always; writes to $0 are ignored.
  - Write occurs at posedge when wb_en=1.
  - Read bypass: if wb_en=1 and wb_addr equals the read address (nonzero) in the same cycle, the read returns wb_data.
- Load-use hazard: stall = ex_mem_read & (ex_dest != 0) & (ex_dest == IF/ID rs, or ex_dest == IF/ID rt where the instruction uses rt as a source: R-type, SW, BEQ).
- While stall = 1:
  - IF/ID holds its contents.
  - ID/EX loads a bubble (all outputs 0).
  - Stall lasts exactly one cycle per hazard.
- Flush (flush=1, reset=0): IF/ID loads NOP and RESET_PC; ID/EX loads a bubble. Flush overrides stall. stall is forced 0 in the cycle flush=1.
- Reset mid-stall: the next edge clears everything; stall = 0 afterward.
- A write-back on the same edge as a stall is still performed.

Decomposition:
- Shared package mips_pkg:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ
  - funct constants
  - ALU codes: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLT=4
  - control-bundle struct typedef
- Sub-module reg_file: 2 read ports, 1 write port, $0 hardwired, write-first bypass, synchronous reset clear.
- Decode, hazard detection and the pipeline registers stay in id_stage.

Test Plan:
- Reset, then idle cycles -> all ex_* = 0, stall = 0.
- Preload $1=5, $2=7 via wb port; present ADD $3,$1,$2 (0x00221820) -> one cycle later: ex_rs_data=5, ex_rt_data=7, ex_dest=3, ex_alu_op=0, ex_reg_write=1, ex_alu_src=0.
- Present LW $1,4($2) (0x8C410004), then ADD $3,$1,$2 -> in the cycle after LW reaches ID/EX: stall=1 for exactly one cycle and a bubble is inserted; ADD then emerges with ex_dest=3.
- ADDI $4,$0,-1 (0x2004FFFF) -> ex_imm=32'hFFFFFFFF, ex_alu_src=1, ex_dest=4, ex_rs_data=0.
- Present SUB $5,$4,$3 (0x00832822) with wb_en=1, wb_addr=4, wb_data=9 in the same cycle -> ex_rs_data=9 (bypass). A write with wb_addr=0 leaves reads of $0 = 0.
- Present opcode 111111 -> ex_illegal=1 with all controls 0. flush=1 during a stall -> stall=0, next cycle all ex_* = 0.
